nmp_vec_engine: RTL and testbench

Parametrised near-memory vector engine, the next generation of the NMP compute core. It sits behind the NMP AXI-Lite register slave: op/addr/data/vector registers feed its command inputs, and its status/result outputs feed the readable registers. It owns a local word-addressed RAM and adds subtraction, bitwise ops, range checking, an error flag and a cycle counter to the original read/write/add set.

---
 rtl/nmp_pkg.sv | 41 ++++
 rtl/nmp_ram.sv | 34 +++
 rtl/nmp_vec_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_nmp_vec_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmp_pkg.sv
// Shared definitions for the NMP vector engine and its register slave:
// op codes, FSM states, default widths and status bit positions.
package nmp_pkg;

  localparam int NMP_DATA_W = 32;
  localparam int NMP_ADDR_W = 12;

  // Bit positions of the status word as seen by the register slave
  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  typedef enum logic [3:0] {
    OP_WAIT  = 4'd0,
    OP_READ  = 4'd1,
    OP_WRITE = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_WR,
    ST_VA,
    ST_VB,
    ST_VW,
    ST_DONE
  } state_e;

  // True for the element-wise vector ops (ADD..XOR)
  function automatic logic is_vec_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/nmp_ram.sv
// Local word-addressed RAM: single port, synchronous read with one cycle
// of latency. A write cycle leaves the read register untouched.
module nmp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Port access: write, or registered read
  // NOTE: no reset here on purpose -- a resettable array cannot map to RAM macros, and contents must survive reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nmp_vec_engine.sv
// Near-memory vector engine: command FSM, element counter, operand
// register and ALU in front of a private single-port RAM.
module nmp_vec_engine
  import nmp_pkg::*;
#(
  parameter int DATA_W = NMP_DATA_W,
  parameter int ADDR_W = NMP_ADDR_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] veca_i,
  input  logic [ADDR_W-1:0] vecb_i,
  input  logic [ADDR_W-1:0] vecr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [31:0]       cycles_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W+1:0] LIMIT = (ADDR_W + 2)'(DEPTH);

  state_e            state_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] veca_q, vecb_q, vecr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q, busy_q, err_q;
  logic [31:0]       cycles_q;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W+1:0] end_a, end_b, end_r;
  logic              vec_op, reject, empty_vec;

  // Command validation. addr_i spans exactly DEPTH words, so single-word
  // commands can never be out of range; only vector extents are checked.
  assign vec_op    = is_vec_op(op_q);
  assign end_a     = {2'b00, veca_q} + {1'b0, len_q};
  assign end_b     = {2'b00, vecb_q} + {1'b0, len_q};
  assign end_r     = {2'b00, vecr_q} + {1'b0, len_q};
  assign reject    = (op_q > OP_XOR) ||
                     (vec_op && ((end_a > LIMIT) || (end_b > LIMIT) || (end_r > LIMIT)));
  assign empty_vec = vec_op && (len_q == '0);
  assign idx_inc   = idx_q + (ADDR_W + 1)'(1);

  // ALU: A comes from the operand register, B straight off the RAM read port
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + ram_rdata;
      OP_SUB:  alu_res = a_q - ram_rdata;
      OP_AND:  alu_res = a_q & ram_rdata;
      OP_OR:   alu_res = a_q | ram_rdata;
      OP_XOR:  alu_res = a_q ^ ram_rdata;
      default: alu_res = '0;
    endcase
  end

  // RAM port steering by state
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    case (state_q)
      ST_RD_ADDR: ram_en = 1'b1;
      ST_WR: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      ST_VA: begin
        ram_en   = 1'b1;
        ram_addr = veca_q + idx_q[ADDR_W-1:0];
      end
      ST_VB: begin
        ram_en   = 1'b1;
        ram_addr = vecb_q + idx_q[ADDR_W-1:0];
      end
      ST_VW: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = vecr_q + idx_q[ADDR_W-1:0];
        ram_wdata = alu_res;
      end
      default: ;
    endcase
  end

  nmp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (ACLK),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Command FSM with registered status outputs
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      veca_q   <= '0;
      vecb_q   <= '0;
      vecr_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_i != OP_WAIT) begin
            op_q     <= op_i;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            veca_q   <= veca_i;
            vecb_q   <= vecb_i;
            vecr_q   <= vecr_i;
            len_q    <= len_i;
            cycles_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          cycles_q <= cycles_q + 32'd1;
          err_q    <= reject;
          idx_q    <= '0;
          if (reject || empty_vec) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (op_q == OP_READ) begin
            state_q <= ST_RD_ADDR;
          end else if (op_q == OP_WRITE) begin
            state_q <= ST_WR;
          end else begin
            state_q <= ST_VA;
          end
        end
        ST_RD_ADDR: begin
          cycles_q <= cycles_q + 32'd1;
          state_q  <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          cycles_q <= cycles_q + 32'd1;
          rdata_q  <= ram_rdata;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_WR: begin
          cycles_q <= cycles_q + 32'd1;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_VA: begin
          cycles_q <= cycles_q + 32'd1;
          state_q  <= ST_VB;
        end
        ST_VB: begin
          cycles_q <= cycles_q + 32'd1;
          a_q      <= ram_rdata;
          state_q  <= ST_VW;
        end
        ST_VW: begin
          cycles_q <= cycles_q + 32'd1;
          if (idx_inc < len_q) begin
            idx_q   <= idx_inc;
            state_q <= ST_VA;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (op_i == OP_WAIT) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata_o  = rdata_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;
  assign cycles_o = cycles_q;

endmodule

// File: tb/tb_nmp_vec_engine.sv
// Directed bench for nmp_vec_engine: a vector table for the single-command
// cases, then hand-written sequences for the multi-cycle corner cases.
module tb_nmp_vec_engine;
  import nmp_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [3:0]    op_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [AW-1:0] veca_i, vecb_i, vecr_i;
  logic [AW:0]   len_i;
  logic [DW-1:0] rdata_o;
  logic          done_o, busy_o, err_o;
  logic [31:0]   cycles_o;

  nmp_vec_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .op_i     (op_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .veca_i   (veca_i),
    .vecb_i   (vecb_i),
    .vecr_i   (vecr_i),
    .len_i    (len_i),
    .rdata_o  (rdata_o),
    .done_o   (done_o),
    .busy_o   (busy_o),
    .err_o    (err_o),
    .cycles_o (cycles_o)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic [3:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [11:0] va, vb, vr;
    logic [12:0] len;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_cyc;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input int op, input int addr, input int wd, input int va,
                              input int vb, input int vr, input int len, input int rd,
                              input int er, input int cyc);
    vec_t v;
    v.op        = 4'(op);
    v.addr      = 12'(addr);
    v.wdata     = 32'(wd);
    v.va        = 12'(va);
    v.vb        = 12'(vb);
    v.vr        = 12'(vr);
    v.len       = 13'(len);
    v.exp_rdata = 32'(rd);
    v.exp_err   = 1'(er);
    v.exp_cyc   = 32'(cyc);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Element-by-element in ascending order, matching sequential memory semantics
  task automatic apply_model(input logic [3:0] op, input int va, input int vb, input int vr,
                             input int len);
    for (int i = 0; i < len; i++) model[vr + i] = alu_model(op, model[va + i], model[vb + i]);
  endtask

  // Present a command and wait (bounded) for done_o
  task automatic issue(input logic [3:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [11:0] va, input logic [11:0] vb, input logic [11:0] vr,
                       input logic [12:0] len, input bit chk_busy);
    bit seen;
    @(negedge ACLK);
    op_i    = op;
    addr_i  = addr;
    wdata_i = wd;
    veca_i  = va;
    vecb_i  = vb;
    vecr_i  = vr;
    len_i   = len;
    @(negedge ACLK);
    if (chk_busy) check("busy_in_check", 32'(busy_o), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      if (done_o) seen = 1'b1;
      else @(negedge ACLK);
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: done_o=0 after 6000 cycles, expected 1");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "engine never completed");
    end
  endtask

  // Drop back to WAIT; done_o must clear one cycle later
  task automatic release_cmd();
    op_i = OP_WAIT;
    @(negedge ACLK);
    check("done_clears", 32'(done_o), 32'd0);
  endtask

  task automatic wr(input int addr, input logic [31:0] val);
    issue(OP_WRITE, 12'(addr), val, '0, '0, '0, '0, 1'b0);
    model[addr] = val;
    op_i = OP_WAIT;
    @(negedge ACLK);
  endtask

  task automatic check_mem(input string name, input int addr, input logic [31:0] exp);
    check(name, dut.u_ram.mem_q[addr], exp);
  endtask

  initial begin
    logic [31:0] tmp;
    logic [3:0]  rop;
    int          rlen;
    int          bad_cnt;

    ARESET  = 1'b1;
    op_i    = OP_WAIT;
    addr_i  = '0;
    wdata_i = '0;
    veca_i  = '0;
    vecb_i  = '0;
    vecr_i  = '0;
    len_i   = '0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);

    check("rst_done",   32'(done_o), 32'd0);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_err",    32'(err_o),  32'd0);
    check("rst_cycles", cycles_o,    32'd0);
    check("rst_rdata",  rdata_o,     32'd0);

    //             op addr  wd  va    vb    vr    len rdata err cyc
    tbl[0]  = mk(2, 2,    16, 0,    0,    0,    0,   0,    0,  2);
    tbl[1]  = mk(2, 4,    32, 0,    0,    0,    0,   0,    0,  2);
    tbl[2]  = mk(1, 2,    0,  0,    0,    0,    0,   16,   0,  3);
    tbl[3]  = mk(3, 0,    0,  2,    4,    8,    1,   16,   0,  4);
    tbl[4]  = mk(1, 8,    0,  0,    0,    0,    0,   48,   0,  3);
    tbl[5]  = mk(3, 0,    0,  4000, 4,    8,    100, 48,   1,  1);
    tbl[6]  = mk(9, 2,    0,  0,    0,    0,    0,   48,   1,  1);
    tbl[7]  = mk(3, 0,    0,  4,    4,    8,    0,   48,   0,  1);
    tbl[8]  = mk(1, 8,    0,  0,    0,    0,    0,   48,   0,  3);
    tbl[9]  = mk(3, 0,    0,  4095, 4095, 4094, 1,   48,   0,  4);
    tbl[10] = mk(4, 0,    0,  0,    4000, 100,  97,  48,   1,  1);
    tbl[11] = mk(7, 0,    0,  0,    100,  4090, 7,   48,   1,  1);
    tbl[12] = mk(1, 4,    0,  0,    0,    0,    0,   32,   0,  3);

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].va, tbl[i].vb, tbl[i].vr,
            tbl[i].len, 1'b1);
      check($sformatf("vec%0d_err", i),    32'(err_o), 32'(tbl[i].exp_err));
      check($sformatf("vec%0d_cycles", i), cycles_o,   tbl[i].exp_cyc);
      check($sformatf("vec%0d_rdata", i),  rdata_o,    tbl[i].exp_rdata);
      if (tbl[i].op == 4'd2) model[tbl[i].addr] = tbl[i].wdata;
      if (is_vec_op(tbl[i].op) && !tbl[i].exp_err)
        apply_model(tbl[i].op, int'(tbl[i].va), int'(tbl[i].vb), int'(tbl[i].vr),
                    int'(tbl[i].len));
      release_cmd();
    end

    // SUB with wrap-around
    wr(100, 32'd5);
    wr(101, 32'd0);
    wr(110, 32'd7);
    wr(111, 32'd1);
    issue(OP_SUB, '0, '0, 12'd100, 12'd110, 12'd120, 13'd2, 1'b1);
    check("sub_cycles", cycles_o, 32'd7);
    release_cmd();
    check_mem("sub_r0", 120, 32'hFFFF_FFFE);
    check_mem("sub_r1", 121, 32'hFFFF_FFFF);

    // ADD overflow wraps to zero
    wr(130, 32'hFFFF_FFFF);
    wr(131, 32'd1);
    issue(OP_ADD, '0, '0, 12'd130, 12'd131, 12'd132, 13'd1, 1'b0);
    check("add_wrap_err", 32'(err_o), 32'd0);
    release_cmd();
    check_mem("add_wrap", 132, 32'd0);

    // XOR fully in place, R == A
    wr(140, 32'h0000_F0F0);
    wr(141, 32'h0000_FFFF);
    issue(OP_XOR, '0, '0, 12'd140, 12'd141, 12'd140, 13'd1, 1'b0);
    release_cmd();
    check_mem("xor_inplace", 140, 32'h0000_0F0F);

    // AND / OR over 8 random words
    for (int i = 0; i < 8; i++) begin
      wr(200 + i, $urandom);
      wr(210 + i, $urandom);
    end
    issue(OP_AND, '0, '0, 12'd200, 12'd210, 12'd220, 13'd8, 1'b0);
    release_cmd();
    issue(OP_OR, '0, '0, 12'd200, 12'd210, 12'd230, 13'd8, 1'b0);
    release_cmd();
    for (int i = 0; i < 8; i++) begin
      check_mem($sformatf("and_%0d", i), 220 + i, model[200 + i] & model[210 + i]);
      check_mem($sformatf("or_%0d", i),  230 + i, model[200 + i] | model[210 + i]);
    end

    // Holding ADD through DONE must execute it only once
    wr(300, 32'd3);
    wr(301, 32'd5);
    issue(OP_ADD, '0, '0, 12'd300, 12'd301, 12'd300, 13'd1, 1'b0);
    repeat (5) @(negedge ACLK);
    check("hold_done",   32'(done_o), 32'd1);
    check("hold_busy",   32'(busy_o), 32'd0);
    check("hold_cycles", cycles_o,    32'd4);
    release_cmd();
    check_mem("hold_once", 300, 32'd8);

    // Reset asserted during VW of element 4 of a 10-element ADD
    for (int i = 0; i < 10; i++) begin
      wr(400 + i, 32'(i + 1));
      wr(410 + i, 32'(100 * (i + 1)));
      wr(420 + i, 32'hDEAD_0000 + 32'(i));
    end
    issue(OP_READ, 12'd8, '0, '0, '0, '0, '0, 1'b0);
    check("pre_rst_rdata", rdata_o, 32'd48);
    release_cmd();
    @(negedge ACLK);
    op_i   = OP_ADD;
    veca_i = 12'd400;
    vecb_i = 12'd410;
    vecr_i = 12'd420;
    len_i  = 13'd10;
    @(negedge ACLK);
    repeat (15) @(negedge ACLK);
    check("mid_busy", 32'(busy_o), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    op_i   = OP_WAIT;
    check("abort_done",   32'(done_o), 32'd0);
    check("abort_busy",   32'(busy_o), 32'd0);
    check("abort_err",    32'(err_o),  32'd0);
    check("abort_cycles", cycles_o,    32'd0);
    check("abort_rdata",  rdata_o,     32'd0);
    for (int i = 0; i < 4; i++)
      check_mem($sformatf("abort_done_el%0d", i), 420 + i, 32'(101 * (i + 1)));
    for (int i = 5; i < 10; i++)
      check_mem($sformatf("abort_untouched_el%0d", i), 420 + i, 32'hDEAD_0000 + 32'(i));
    issue(OP_READ, 12'd2, '0, '0, '0, '0, '0, 1'b1);
    check("post_rst_rdata",  rdata_o,  32'd16);
    check("post_rst_cycles", cycles_o, 32'd3);
    release_cmd();

    // Random lengths on disjoint ranges: A @0, B @1365, R @2730
    for (int i = 0; i < 2730; i++) begin
      tmp = $urandom;
      wr(i, tmp);
    end
    for (int it = 0; it < 16; it++) begin
      rop  = 4'($urandom_range(3, 7));
      rlen = int'($urandom_range(1, 1365));
      issue(rop, '0, '0, 12'd0, 12'd1365, 12'd2730, 13'(rlen), 1'b0);
      check($sformatf("rand%0d_err", it),    32'(err_o), 32'd0);
      check($sformatf("rand%0d_cycles", it), cycles_o,   32'(1 + 3 * rlen));
      release_cmd();
      apply_model(rop, 0, 1365, 2730, rlen);
      bad_cnt = 0;
      for (int k = 0; k < rlen; k++)
        if (dut.u_ram.mem_q[2730 + k] !== model[2730 + k]) bad_cnt++;
      check($sformatf("rand%0d_R_bad_words", it), 32'(bad_cnt), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
